// File: rtl/reduction_accumulator.sv
// Purpose: sums the four byte lanes of each operand beat into a 16-bit saturating total.
// Latency: result valid the cycle after the last beat transfers; single-beat minimum is 2 cycles.
// Backpressure: in_ready drops while a result is held; the result holds until out_ready; clr aborts.
module reduction_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_A,
    input  logic [15:0]      in_B,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               out_valid_q;

    logic [9:0]         beat;
    logic [16:0]        sum17;
    logic [CNT_W-1:0]   cnt_inc;
    logic               xfer;

    // Lane sum is at most 4*255 = 1020, so 10 bits never overflow.
    assign beat  = {2'b00, in_A[7:0]} + {2'b00, in_B[7:0]}
                 + {2'b00, in_A[15:8]} + {2'b00, in_B[15:8]};
    assign sum17 = {1'b0, acc_q} + {7'b0, beat};

    // The beat counter sticks at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // clr must block the beat in the same cycle, so in_ready stays combinational.
    assign in_ready = (state_q != S_HOLD) && !clr;
    assign xfer     = in_valid && in_ready;

    // Next-state and datapath update; clr overrides everything, including a pending result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    acc_d   = {6'b0, beat};
                    cnt_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                    state_d = in_last ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    if (sum17[16]) begin
                        acc_d = 16'hFFFF;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum17[15:0];
                    end
                    cnt_d = cnt_inc;
                    if (in_last) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
            acc_d   = 16'h0000;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end
    end

    // State, accumulator and registered result-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 16'h0000;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= (state_d == S_HOLD);
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;
    assign out_beats = cnt_q;

endmodule

// File: tb/tb_reduction_accumulator.sv
// Purpose: directed checks of the byte-lane reduction engine with hand-computed results.
// Latency: samples outputs 1ns after each rising edge; drives inputs at the same point.
// Backpressure: exercises result hold under out_ready=0, clr abort and async reset.
module tb_reduction_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_sat;
    logic [7:0]  out_beats;

    int n_vec;
    int n_err;

    reduction_accumulator #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .out_beats (out_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and let it cross an edge; in_valid is left asserted.
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        in_last  = last;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check the held result, then hand it off and confirm return to IDLE.
    task automatic expect_result(input string tag, input logic [15:0] sum,
                                 input logic sat, input logic [7:0] beats);
        chk({tag, "_vld"},   out_valid, 1'b1);
        chk({tag, "_sum"},   out_sum, sum);
        chk({tag, "_sat"},   out_sat, sat);
        chk({tag, "_beats"}, out_beats, beats);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done"},  out_valid, 1'b0);
        chk({tag, "_rdy"},   in_ready, 1'b1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_A      = 16'h0;
        in_B      = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_vld",   out_valid, 1'b0);
        chk("rst_sum",   out_sum, 16'h0);
        chk("rst_sat",   out_sat, 1'b0);
        chk("rst_beats", out_beats, 8'd0);
        #9 rst_n = 1'b1;
        step();
        chk("rst_rdy", in_ready, 1'b1);

        // 1: single beat, 1+2+3+4 = 10
        beat(16'h0102, 16'h0304, 1'b1);
        idle();
        chk("t1_inrdy", in_ready, 1'b0);
        expect_result("t1", 16'h000A, 1'b0, 8'd1);

        // 2: three beats of 1020 -> 3060
        beat(16'hFFFF, 16'hFFFF, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b0);
        chk("t2_mid_vld", out_valid, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b1);
        idle();
        expect_result("t2", 16'h0BF4, 1'b0, 8'd3);

        // 3: 65 beats of 1020 -> 66300 saturates; next reduction clean
        for (int i = 0; i < 65; i++) beat(16'hFFFF, 16'hFFFF, (i == 64));
        idle();
        expect_result("t3", 16'hFFFF, 1'b1, 8'd65);
        beat(16'h0001, 16'h0000, 1'b1);
        idle();
        expect_result("t3b", 16'h0001, 1'b0, 8'd1);

        // 4: result held under backpressure, pending beat not accepted
        beat(16'h0101, 16'h0101, 1'b1);
        in_A    = 16'h1010;
        in_B    = 16'h0000;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_inrdy", in_ready, 1'b0);
            chk("t4_sum",   out_sum, 16'h0004);
            chk("t4_vld",   out_valid, 1'b1);
            step();
        end
        chk("t4_beats", out_beats, 8'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_idle_vld", out_valid, 1'b0);
        chk("t4_idle_rdy", in_ready, 1'b1);
        step();
        idle();
        expect_result("t4b", 16'h0020, 1'b0, 8'd1);

        // 5: clr after two beats blocks the concurrent beat and drops the work
        beat(16'h0101, 16'h0000, 1'b0);
        beat(16'h0101, 16'h0000, 1'b0);
        chk("t5_partial", out_sum, 16'h0004);
        in_valid = 1'b1;
        in_A     = 16'h0101;
        in_last  = 1'b1;
        clr      = 1'b1;
        #1;
        chk("t5_clr_rdy", in_ready, 1'b0);
        step();
        clr = 1'b0;
        idle();
        chk("t5_vld",   out_valid, 1'b0);
        chk("t5_sum",   out_sum, 16'h0000);
        chk("t5_beats", out_beats, 8'd0);
        step();
        chk("t5_vld2",  out_valid, 1'b0);
        beat(16'h0505, 16'h0000, 1'b1);
        idle();
        expect_result("t5b", 16'h000A, 1'b0, 8'd1);

        // 6: async reset between edges while accumulating
        beat(16'h0101, 16'h0101, 1'b0);
        beat(16'h0101, 16'h0101, 1'b0);
        idle();
        chk("t6_pre_beats", out_beats, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sum",   out_sum, 16'h0000);
        chk("t6_beats", out_beats, 8'd0);
        chk("t6_vld",   out_valid, 1'b0);
        step();
        chk("t6_hold_vld", out_valid, 1'b0);
        #3 rst_n = 1'b1;
        step();
        beat(16'h0102, 16'h0304, 1'b1);
        idle();
        expect_result("t6b", 16'h000A, 1'b0, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
